// File: rtl/ysyx_24080006_icache_nway.sv
// N-way set-associative instruction cache with an AXI read-burst refill port.
// Optional hit/miss performance counters are built only when the
// YSYX_ICACHE_PERF_EN macro is defined; otherwise both perf ports read 0.

package ysyx_24080006_icache_nway_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } axi_r_s2m_t;

endpackage

module ysyx_24080006_icache_nway
    import ysyx_24080006_icache_nway_pkg::*;
#(
    parameter int LINE_LOG2 = 5,
    parameter int SET_LOG2  = 1,
    parameter int WAYS      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        flush,
    output axi_r_m2s_t  axi_r_o,
    input  axi_r_s2m_t  axi_r_i,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
);

    localparam int SETS   = 1 << SET_LOG2;
    localparam int WORDS  = 1 << (LINE_LOG2 - 2);
    localparam int WOFF_W = LINE_LOG2 - 2;
    localparam int IDX_W  = (SET_LOG2 > 0) ? SET_LOG2 : 1;
    localparam int TAG_W  = 32 - LINE_LOG2 - SET_LOG2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_AR     = 3'd2;
    localparam logic [2:0] S_R      = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        r_state;
    logic [31:0]       r_addr;
    logic              r_flushPending;
    logic [SETS-1:0]   r_valid [WAYS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [31:0]       r_data  [WAYS][SETS][WORDS];
    logic [WAY_W-1:0]  r_ptr;
    logic [WAY_W-1:0]  r_victim;
    logic [WOFF_W-1:0] r_beat;
    logic              r_errSeen;
    logic [31:0]       r_rspInst;
    logic              r_rspErr;

    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic [WOFF_W-1:0] w_wordOff;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hitWay;
    logic [WAY_W-1:0]  w_victim;
    logic              w_beatFire;
    logic              w_beatErr;
    logic              w_lineErr;
    logic [WAY_W-1:0]  w_ptrNext;
    logic              w_unused;

    assign w_index    = IDX_W'((r_addr >> LINE_LOG2) & 32'(SETS - 1));
    assign w_tag      = TAG_W'(r_addr >> (LINE_LOG2 + SET_LOG2));
    assign w_wordOff  = r_addr[LINE_LOG2-1:2];
    assign w_beatFire = (r_state == S_R) && axi_r_i.rvalid;
    assign w_beatErr  = (axi_r_i.rresp != 2'b00);
    assign w_lineErr  = r_errSeen || w_beatErr;
    assign w_ptrNext  = (r_ptr == WAY_W'(WAYS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_unused   = ^r_addr[1:0];

    // Tag compare across all ways of the addressed set; at most one way can match.
    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WAY_W'(w);
            end
        end
    end

    // Victim is the lowest-numbered empty way, falling back to the round-robin pointer.
    always_comb begin
        w_victim = r_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_index]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    // Control FSM: request capture, lookup, refill bookkeeping, response hold and flush handling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_flushPending <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
            r_ptr          <= '0;
            r_victim       <= '0;
            r_beat         <= '0;
            r_errSeen      <= 1'b0;
            r_rspInst      <= '0;
            r_rspErr       <= 1'b0;
        end else begin
            if (flush && (r_state != S_IDLE)) begin
                r_flushPending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (flush || r_flushPending) begin
                        for (int w = 0; w < WAYS; w++) begin
                            r_valid[w] <= '0;
                        end
                        r_flushPending <= 1'b0;
                    end else if (req_valid) begin
                        r_addr  <= req_addr;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_rspInst <= r_data[w_hitWay][w_index][w_wordOff];
                        r_rspErr  <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_victim  <= w_victim;
                        r_beat    <= '0;
                        r_errSeen <= 1'b0;
                        r_state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (axi_r_i.arready) begin
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (axi_r_i.rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_wordOff) begin
                            r_rspInst <= axi_r_i.rdata;
                        end
                        if (w_beatErr) begin
                            r_errSeen <= 1'b1;
                        end
                        if (axi_r_i.rlast) begin
                            r_valid[r_victim][w_index] <= !w_lineErr;
                            r_rspErr                   <= w_lineErr;
                            if (!w_lineErr) begin
                                r_ptr <= w_ptrNext;
                            end
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Line storage: refill beats land at word index = beat count; tag written with the last beat.
    always_ff @(posedge clock) begin
        if (w_beatFire) begin
            r_data[r_victim][w_index][r_beat] <= axi_r_i.rdata;
            if (axi_r_i.rlast) begin
                r_tag[r_victim][w_index] <= w_tag;
            end
        end
    end

    // AXI read request fields are only driven while in AR; rready only while in R.
    always_comb begin
        axi_r_o = '0;
        if (r_state == S_AR) begin
            axi_r_o.arvalid = 1'b1;
            axi_r_o.araddr  = {r_addr[31:LINE_LOG2], LINE_LOG2'(0)};
            axi_r_o.arid    = 4'd0;
            axi_r_o.arlen   = 8'(WORDS - 1);
            axi_r_o.arsize  = 3'd2;
            axi_r_o.arburst = 2'b01;
        end
        axi_r_o.rready = (r_state == S_R);
    end

    assign req_ready = !reset && (r_state == S_IDLE) && !r_flushPending && !flush;
    assign rsp_valid = !reset && (r_state == S_RESP);
    assign rsp_inst  = r_rspInst;
    assign rsp_err   = r_rspErr;

`ifdef YSYX_ICACHE_PERF_EN
    logic [31:0] r_perfHit;
    logic [31:0] r_perfMiss;

    // Each lookup counts once, as either a hit or a miss.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perfHit  <= '0;
            r_perfMiss <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                r_perfHit <= r_perfHit + 32'd1;
            end else begin
                r_perfMiss <= r_perfMiss + 32'd1;
            end
        end
    end

    assign perf_hit  = r_perfHit;
    assign perf_miss = r_perfMiss;
`else
    assign perf_hit  = '0;
    assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_ysyx_24080006_icache_nway.sv
// Self-checking bench for ysyx_24080006_icache_nway with default parameters
// (32-byte lines, 2 sets, 2 ways). Includes a simple AXI read slave whose
// memory word at address A is {A[31:2],2'b00} ^ 32'h5A5A_0000.

module tb_ysyx_24080006_icache_nway;
   import ysyx_24080006_icache_nway_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        reqValid;
   logic [31:0] reqAddr;
   logic        reqReady;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspInst;
   logic        rspErr;
   logic        flush;
   axi_r_m2s_t  axiRo;
   axi_r_s2m_t  axiRi;
   logic [31:0] perfHit;
   logic [31:0] perfMiss;

   int checks = 0;
   int failures = 0;

   // reference model: resident line address and valid flag per [set][way]
   logic [31:0] mLine [2][2];
   bit          mValid [2][2];
   int          mPtr;
   int          mHits;
   int          mMisses;

   // expectations consumed by the compare process
   logic [31:0] expLine;
   logic [31:0] expInst;
   logic        expErr;

   // slave controls and observations
   int          slaveErrBeat;
   int          slaveFlushBeat;
   int          arCount = 0;
   logic [31:0] lastAraddr;
   logic [7:0]  lastArlen;
   logic [31:0] lastInst;
   logic        lastErr;

   ysyx_24080006_icache_nway dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (reqValid),
      .req_addr  (reqAddr),
      .req_ready (reqReady),
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_inst  (rspInst),
      .rsp_err   (rspErr),
      .flush     (flush),
      .axi_r_o   (axiRo),
      .axi_r_i   (axiRi),
      .perf_hit  (perfHit),
      .perf_miss (perfMiss)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic modelFlush();
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 2; w++)
            mValid[s][w] = 1'b0;
   endtask

   // One fetch: predict hit/miss from the model, run the handshake, verify latency,
   // AR traffic and response, optionally hold rsp_ready low, then update the model.
   task automatic applyStimulus(input string name, input logic [31:0] addr, input bit litHit,
                                input int errBeat, input int flushBeat, input int holdLow,
                                input bit withFlush);
      int          waitC;
      int          lat;
      int          arBefore;
      int          set;
      int          victim;
      bit          modelHit;
      logic [31:0] line;
      if (withFlush) modelFlush();
      line = addr & 32'hFFFF_FFE0;
      set  = int'(addr[5]);
      modelHit = (mValid[set][0] && mLine[set][0] == line) || (mValid[set][1] && mLine[set][1] == line);
      checkOutput({name, " model hit"}, 32'(modelHit), 32'(litHit));
      expLine = line;
      expInst = memWord(addr);
      expErr  = !modelHit && (errBeat >= 0);
      slaveErrBeat   = errBeat;
      slaveFlushBeat = flushBeat;
      arBefore = arCount;

      @(negedge clock);
      reqValid = 1'b1;
      reqAddr  = addr;
      rspReady = 1'b0;
      if (withFlush) flush = 1'b1;
      #1;
      if (withFlush) begin
         checkOutput({name, " req_ready low under flush"}, 32'(reqReady), 0);
         @(negedge clock);
         flush = 1'b0;
         #1;
      end
      waitC = 0;
      while (!reqReady && waitC < 50) begin
         @(negedge clock);
         #1;
         waitC++;
      end
      if (!reqReady) begin
         checkOutput({name, " accept timeout"}, 32'(reqReady), 1);
         reqValid = 1'b0;
         return;
      end
      @(posedge clock);
      @(negedge clock);
      reqValid = 1'b0;
      lat = 1;
      while (!rspValid && lat < 60) begin
         @(negedge clock);
         lat++;
      end
      checkOutput({name, " rsp_valid arrives"}, 32'(rspValid), 1);
      if (!rspValid) return;
      if (modelHit) checkOutput({name, " hit latency"}, 32'(lat), 2);
      checkOutput({name, " AR bursts issued"}, 32'(arCount - arBefore), modelHit ? 0 : 1);
      checkOutput({name, " rsp_inst"}, rspInst, expInst);
      checkOutput({name, " rsp_err"}, 32'(rspErr), 32'(expErr));
      lastInst = rspInst;
      lastErr  = rspErr;
      for (int i = 0; i < holdLow; i++) begin
         @(negedge clock);
         #1;
         checkOutput({name, " hold rsp_valid"}, 32'(rspValid), 1);
         checkOutput({name, " hold req_ready"}, 32'(reqReady), 0);
      end
      rspReady = 1'b1;
      @(negedge clock);
      rspReady = 1'b0;
      #1;
      checkOutput({name, " rsp_valid drops"}, 32'(rspValid), 0);

      if (modelHit) begin
         mHits++;
      end else begin
         mMisses++;
         victim = mPtr;
         for (int w = 1; w >= 0; w--)
            if (!mValid[set][w]) victim = w;
         if (errBeat >= 0) begin
            mValid[set][victim] = 1'b0;
         end else begin
            mValid[set][victim] = 1'b1;
            mLine[set][victim]  = line;
            mPtr = (mPtr + 1) % 2;
         end
      end
      slaveErrBeat   = -1;
      slaveFlushBeat = -1;
   endtask

   // AXI read slave: accept AR one cycle after seeing it, then stream 8 beats.
   initial begin
      axiRi = '0;
      forever begin
         @(negedge clock);
         if (!reset && axiRo.arvalid) begin
            arCount++;
            lastAraddr = axiRo.araddr;
            lastArlen  = axiRo.arlen;
            axiRi.arready = 1'b1;
            @(negedge clock);
            axiRi.arready = 1'b0;
            for (int b = 0; b < 8; b++) begin
               int w;
               w = 0;
               while (!axiRo.rready && w < 20) begin
                  @(negedge clock);
                  w++;
               end
               if (!axiRo.rready) begin
                  checkOutput("slave rready timeout", 32'(axiRo.rready), 1);
                  break;
               end
               axiRi.rvalid = 1'b1;
               axiRi.rdata  = memWord(lastAraddr + 32'(4 * b));
               axiRi.rresp  = (b == slaveErrBeat) ? 2'b10 : 2'b00;
               axiRi.rlast  = (b == 7);
               if (b == slaveFlushBeat) flush = 1'b1;
               @(negedge clock);
               if (b == slaveFlushBeat) flush = 1'b0;
            end
            axiRi.rvalid = 1'b0;
            axiRi.rlast  = 1'b0;
            axiRi.rresp  = 2'b00;
         end
      end
   end

   // Per-cycle compare of AR fields and held response against the model expectations.
   initial begin
      forever begin
         @(negedge clock);
         #3;
         if (!reset && axiRo.arvalid) begin
            checkOutput("ar araddr", axiRo.araddr, expLine);
            checkOutput("ar arlen", 32'(axiRo.arlen), 7);
            checkOutput("ar arsize", 32'(axiRo.arsize), 2);
            checkOutput("ar arburst", 32'(axiRo.arburst), 1);
            checkOutput("ar arid", 32'(axiRo.arid), 0);
            checkOutput("ar rready", 32'(axiRo.rready), 0);
         end
         if (!reset && rspValid) begin
            checkOutput("resp inst", rspInst, expInst);
            checkOutput("resp err", 32'(rspErr), 32'(expErr));
            checkOutput("resp req_ready", 32'(reqReady), 0);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit perfOk;
      reset = 1'b1;
      reqValid = 1'b0;
      reqAddr = '0;
      rspReady = 1'b0;
      flush = 1'b0;
      slaveErrBeat = -1;
      slaveFlushBeat = -1;
      mPtr = 0;
      mHits = 0;
      mMisses = 0;
      modelFlush();
      repeat (3) @(negedge clock);
      #1;
      checkOutput("reset req_ready", 32'(reqReady), 0);
      checkOutput("reset rsp_valid", 32'(rspValid), 0);
      checkOutput("reset arvalid", 32'(axiRo.arvalid), 0);
      checkOutput("reset rready", 32'(axiRo.rready), 0);
      checkOutput("reset rsp_inst", rspInst, 0);
      checkOutput("reset rsp_err", 32'(rspErr), 0);
      checkOutput("reset perf_hit", perfHit, 0);
      checkOutput("reset perf_miss", perfMiss, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("req_ready after reset", 32'(reqReady), 1);

      applyStimulus("cold 30000004", 32'h3000_0004, 0, -1, -1, 0, 0);
      checkOutput("cold araddr literal", lastAraddr, 32'h3000_0000);
      checkOutput("cold arlen literal", 32'(lastArlen), 7);
      checkOutput("cold inst literal", lastInst, 32'h6A5A_0004);
      checkOutput("cold err literal", 32'(lastErr), 0);

      applyStimulus("hit 30000008", 32'h3000_0008, 1, -1, -1, 0, 0);
      checkOutput("hit inst literal", lastInst, 32'h6A5A_0008);

      applyStimulus("rr 30000000", 32'h3000_0000, 1, -1, -1, 0, 0);
      applyStimulus("rr 30000040", 32'h3000_0040, 0, -1, -1, 0, 0);
      applyStimulus("rr 30000080", 32'h3000_0080, 0, -1, -1, 0, 0);
      applyStimulus("rr 30000000 evicted", 32'h3000_0000, 0, -1, -1, 0, 0);
      applyStimulus("rr 30000004 resident", 32'h3000_0004, 1, -1, -1, 0, 0);

      applyStimulus("err 30000020", 32'h3000_0020, 0, 3, -1, 0, 0);
      checkOutput("err flag literal", 32'(lastErr), 1);
      applyStimulus("err refetch 30000024", 32'h3000_0024, 0, -1, -1, 0, 0);
      checkOutput("refetch err literal", 32'(lastErr), 0);
      applyStimulus("hit 3000003C", 32'h3000_003C, 1, -1, -1, 0, 0);
      checkOutput("last word literal", lastInst, 32'h6A5A_003C);

      applyStimulus("flush in R 30000100", 32'h3000_0100, 0, -1, 2, 0, 0);
      modelFlush();
      applyStimulus("after flush 30000104", 32'h3000_0104, 0, -1, -1, 0, 0);

      applyStimulus("hold 30000108", 32'h3000_0108, 1, -1, -1, 10, 0);
      applyStimulus("flush+req 30000108", 32'h3000_0108, 0, -1, -1, 0, 1);

      perfOk = ((perfHit == 32'(mHits)) && (perfMiss == 32'(mMisses))) ||
               ((perfHit == 32'd0) && (perfMiss == 32'd0));
      checkOutput("perf counters", 32'(perfOk), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
